// File: rtl/hack_cpu_ctrl_pkg.sv
// Shared definitions for the Hack CPU controller.
// Holds the control FSM state encoding, the bit positions of the
// instruction fields (a, c[5:0], d[2:0], j[2:0]), the 6-bit ALU control
// words {zx,nx,zy,ny,f,no} and a program-counter increment helper.
package hack_cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_MREAD  = 2'd2,
    ST_EXEC   = 2'd3
  } state_e;

  // Instruction field positions
  localparam int IR_CI   = 15;  // 1 = C-instruction, 0 = A-instruction
  localparam int IR_A    = 12;  // ALU y operand: 1 = M, 0 = A
  localparam int IR_C_HI = 11;  // comp field c[5:0] = IR[11:6]
  localparam int IR_C_LO = 6;
  localparam int IR_D_A  = 5;   // dest A
  localparam int IR_D_D  = 4;   // dest D
  localparam int IR_D_M  = 3;   // dest M (memory write)
  localparam int IR_J_HI = 2;   // jump field j[2:0] = {lt, eq, gt}
  localparam int IR_J_LO = 0;

  // ALU control words {zx,nx,zy,ny,f,no}
  localparam logic [5:0] ALU_ZERO     = 6'b101010;
  localparam logic [5:0] ALU_ONE      = 6'b111111;
  localparam logic [5:0] ALU_NEG_ONE  = 6'b111010;
  localparam logic [5:0] ALU_X        = 6'b001100;
  localparam logic [5:0] ALU_Y        = 6'b110000;
  localparam logic [5:0] ALU_NOT_X    = 6'b001101;
  localparam logic [5:0] ALU_NOT_Y    = 6'b110001;
  localparam logic [5:0] ALU_X_PLUS1  = 6'b011111;
  localparam logic [5:0] ALU_Y_PLUS1  = 6'b110111;
  localparam logic [5:0] ALU_X_MINUS1 = 6'b001110;
  localparam logic [5:0] ALU_Y_MINUS1 = 6'b110010;
  localparam logic [5:0] ALU_X_PLUS_Y = 6'b000010;
  localparam logic [5:0] ALU_X_AND_Y  = 6'b000000;
  localparam logic [5:0] ALU_X_OR_Y   = 6'b010101;

  // 15-bit increment; wraps 0x7FFF -> 0x0000 by width.
  function automatic logic [14:0] pc_inc(input logic [14:0] pc);
    return pc + 15'd1;
  endfunction

endpackage

// File: rtl/hack_cpu_ctrl_jump.sv
// hack_jump_unit: evaluates the Hack jump condition from the ALU result.
// Ports:
//   alu_out_i  [15:0] ALU result of the executing C-instruction
//   jmp_i      [2:0]  jump field {lt, eq, gt}
//   jump_o            1 when the program counter must load A
module hack_jump_unit (
  input  logic [15:0] alu_out_i,
  input  logic [2:0]  jmp_i,
  output logic        jump_o
);

  logic zr;
  logic ng;

  assign zr     = (alu_out_i == 16'h0000);
  assign ng     = alu_out_i[15];
  assign jump_o = (jmp_i[2] & ng) | (jmp_i[1] & zr) | (jmp_i[0] & ~zr & ~ng);

endmodule

// File: rtl/hack_cpu_ctrl.sv
// hack_cpu_ctrl: multi-cycle control unit for a Hack CPU with an external ALU.
// FSM FETCH -> DECODE -> [MREAD] -> EXEC; A-instructions retire in DECODE.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   imem_req/imem_addr/imem_data/imem_ack   instruction fetch handshake
//   dmem_addr/dmem_wdata/dmem_we/dmem_rdata data memory (read data one cycle
//                                           after the address)
//   alu_x/alu_y/alu_signal/alu_out/alu_cout external ALU (carry ignored)
//   pc                              current program counter
//   halted                          self-jump halt flag
// Build option: define HACK_CTRL_HALT_EN to stop on a C-instruction that
// jumps to its own address; otherwise halted is tied low.
module hack_cpu_ctrl
  import hack_cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [14:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_ack,
  output logic [14:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  output logic        dmem_we,
  input  logic [15:0] dmem_rdata,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic [5:0]  alu_signal,
  input  logic [15:0] alu_out,
  input  logic        alu_cout,
  output logic [14:0] pc,
  output logic        halted
);

  state_e      state_q, state_d;
  logic [14:0] pc_q, pc_d;
  logic [15:0] a_q, a_d;
  logic [15:0] d_q, d_d;
  logic [15:0] m_q, m_d;
  logic [15:0] ir_q, ir_d;
  logic        halted_q;
  logic        jump;
  logic        unused_cout;

  assign unused_cout = alu_cout;

  hack_jump_unit u_jump (
    .alu_out_i (alu_out),
    .jmp_i     (ir_q[IR_J_HI:IR_J_LO]),
    .jump_o    (jump)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= 15'h0000;
      a_q     <= 16'h0000;
      d_q     <= 16'h0000;
      m_q     <= 16'h0000;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      d_q     <= d_d;
      m_q     <= m_d;
      ir_q    <= ir_d;
    end
  end

`ifdef HACK_CTRL_HALT_EN
  logic halted_d;
  // Self-jump compares against the pre-write A, same as the jump target.
  assign halted_d = halted_q | ((state_q == ST_EXEC) && jump && (a_q[14:0] == pc_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halted_q <= 1'b0;
    else        halted_q <= halted_d;
  end
`else
  assign halted_q = 1'b0;
`endif

  // Next-state and datapath register updates
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    a_d     = a_q;
    d_d     = d_q;
    m_d     = m_q;
    ir_d    = ir_q;
    case (state_q)
      ST_FETCH: begin
        if (!halted_q && imem_ack) begin
          ir_d    = imem_data;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!ir_q[IR_CI]) begin
          a_d     = {1'b0, ir_q[14:0]};
          pc_d    = pc_inc(pc_q);
          state_d = ST_FETCH;
        end else begin
          state_d = ir_q[IR_A] ? ST_MREAD : ST_EXEC;
        end
      end
      ST_MREAD: begin
        m_d     = dmem_rdata;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (ir_q[IR_D_D]) d_d = alu_out;
        if (ir_q[IR_D_A]) a_d = alu_out;
        // Jump target is the A value the instruction started with.
        pc_d    = jump ? a_q[14:0] : pc_inc(pc_q);
        state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Outputs
  always_comb begin
    imem_req   = 1'b0;
    imem_addr  = 15'h0000;
    dmem_addr  = 15'h0000;
    dmem_wdata = 16'h0000;
    dmem_we    = 1'b0;
    alu_x      = 16'h0000;
    alu_y      = 16'h0000;
    alu_signal = 6'b000000;
    case (state_q)
      ST_FETCH: begin
        // Gated by rst_n so no fetch is requested while reset is held.
        imem_req  = rst_n & ~halted_q;
        imem_addr = pc_q;
      end
      ST_DECODE: begin
        if (ir_q[IR_CI]) dmem_addr = a_q[14:0];
      end
      ST_MREAD: begin
        dmem_addr = a_q[14:0];
      end
      ST_EXEC: begin
        alu_x      = d_q;
        alu_y      = ir_q[IR_A] ? m_q : a_q;
        alu_signal = ir_q[IR_C_HI:IR_C_LO];
        dmem_addr  = a_q[14:0];
        if (ir_q[IR_D_M]) begin
          dmem_we    = 1'b1;
          dmem_wdata = alu_out;
        end
      end
      default: ;
    endcase
  end

  assign pc     = pc_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Directed testbench for hack_cpu_ctrl with instruction/data memory and
// Hack ALU models. Honors HACK_CTRL_HALT_EN for the self-jump scenario.
module tb_hack_cpu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [14:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_ack;
  logic [14:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_we;
  logic [15:0] dmem_rdata;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [5:0]  alu_signal;
  logic [15:0] alu_out;
  logic        alu_cout;
  logic [14:0] pc;
  logic        halted;

  logic [15:0] prog [0:32767];
  logic [15:0] dmem [0:32767];
  logic        ack_hold;
  logic        wr_clr;
  int          we_cnt;
  logic [14:0] we_addr;
  logic [15:0] we_data;
  int          checks;
  int          failures;

  hack_cpu_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .imem_ack   (imem_ack),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_we    (dmem_we),
    .dmem_rdata (dmem_rdata),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_signal (alu_signal),
    .alu_out    (alu_out),
    .alu_cout   (alu_cout),
    .pc         (pc),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-wait instruction memory unless ack_hold stalls it.
  assign imem_data = prog[imem_addr];
  assign imem_ack  = imem_req & ~ack_hold;
  assign alu_cout  = 1'b0;

  function automatic logic [15:0] hack_alu(input logic [15:0] x_in,
                                           input logic [15:0] y_in,
                                           input logic [5:0]  s);
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] r;
    x = x_in;
    y = y_in;
    if (s[5]) x = 16'h0000;
    if (s[4]) x = ~x;
    if (s[3]) y = 16'h0000;
    if (s[2]) y = ~y;
    r = s[1] ? (x + y) : (x & y);
    if (s[0]) r = ~r;
    return r;
  endfunction

  always_comb alu_out = hack_alu(alu_x, alu_y, alu_signal);

  // Data memory read port (one-cycle latency) and write monitor.
  always @(posedge clk) begin
    dmem_rdata <= dmem[dmem_addr];
    if (wr_clr) begin
      we_cnt <= 0;
    end else if (dmem_we) begin
      we_cnt  <= we_cnt + 1;
      we_addr <= dmem_addr;
      we_data <= dmem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mem;
    for (int i = 0; i < 32768; i++) begin
      prog[i] = 16'h0000;
      dmem[i] = 16'h0000;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reset for two cycles, release on a falling edge.
  task automatic restart;
    rst_n  = 1'b0;
    wr_clr = 1'b1;
    step(2);
    wr_clr = 1'b0;
    rst_n  = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    wr_clr   = 1'b1;
    ack_hold = 1'b0;
    clear_mem;

    // @0x45 ; D=A
    prog[0] = 16'h0045;
    prog[1] = 16'hEC10;
    step(2);
    chk("rst_imem_req_held", 32'(imem_req), 32'h0);
    wr_clr = 1'b0;
    rst_n  = 1'b1;
    step(2);
    chk("a_type_2cyc_pc", 32'(pc), 32'h1);

    // Asynchronous reset while a fetch is outstanding
    #3 rst_n = 1'b0;
    #1;
    chk("arst_imem_req", 32'(imem_req), 32'h0);
    chk("arst_imem_addr", 32'(imem_addr), 32'h0);
    chk("arst_pc", 32'(pc), 32'h0);
    chk("arst_dmem_we", 32'(dmem_we), 32'h0);
    chk("arst_dmem_addr", 32'(dmem_addr), 32'h0);
    chk("arst_alu_sig", 32'(alu_signal), 32'h0);
    chk("arst_alu_x", 32'(alu_x), 32'h0);
    chk("arst_halted", 32'(halted), 32'h0);
    chk("arst_A", 32'(dut.a_q), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_imem_req", 32'(imem_req), 32'h1);
    chk("post_rst_imem_addr", 32'(imem_addr), 32'h0);

    // Program @0x45 ; D=A
    step(4);
    chk("exec_alu_signal", 32'(alu_signal), 32'h30);
    chk("exec_alu_y", 32'(alu_y), 32'h45);
    chk("exec_alu_x", 32'(alu_x), 32'h0);
    chk("exec_no_we", 32'(dmem_we), 32'h0);
    step(1);
    chk("dA_pc", 32'(pc), 32'h2);
    chk("dA_A", 32'(dut.a_q), 32'h45);
    chk("dA_D", 32'(dut.d_q), 32'h45);

    // Fetch stalls while imem_ack is low
    ack_hold = 1'b1;
    restart;
    step(3);
    chk("stall_pc", 32'(pc), 32'h0);
    chk("stall_req", 32'(imem_req), 32'h1);
    ack_hold = 1'b0;
    step(2);
    chk("stall_release_pc", 32'(pc), 32'h1);

    // @0x45 ; D=A ; @0x40 ; M=D+A
    clear_mem;
    prog[0] = 16'h0045;
    prog[1] = 16'hEC10;
    prog[2] = 16'h0040;
    prog[3] = 16'hE088;
    restart;
    step(10);
    chk("mdpa_we_cnt", 32'(we_cnt), 32'h1);
    chk("mdpa_we_addr", 32'(we_addr), 32'h40);
    chk("mdpa_we_data", 32'(we_data), 32'h85);
    chk("mdpa_pc", 32'(pc), 32'h4);

    // @0x33 ; D=A ; @0x10 ; AM=M+1 with M[0x10]=0x7FFF
    clear_mem;
    prog[0] = 16'h0033;
    prog[1] = 16'hEC10;
    prog[2] = 16'h0010;
    prog[3] = 16'hFDE8;
    dmem[16] = 16'h7FFF;
    restart;
    step(10);
    chk("amm1_mread_pc", 32'(pc), 32'h3);
    step(1);
    chk("amm1_pc", 32'(pc), 32'h4);
    chk("amm1_we_cnt", 32'(we_cnt), 32'h1);
    chk("amm1_we_addr", 32'(we_addr), 32'h10);
    chk("amm1_we_data", 32'(we_data), 32'h8000);
    chk("amm1_A", 32'(dut.a_q), 32'h8000);
    chk("amm1_D", 32'(dut.d_q), 32'h33);

    // D=-1 ; @0x123 ; D;JLT
    clear_mem;
    prog[0] = 16'hEE90;
    prog[1] = 16'h0123;
    prog[2] = 16'hE304;
    restart;
    step(8);
    chk("jlt_D", 32'(dut.d_q), 32'hFFFF);
    chk("jlt_pc", 32'(pc), 32'h123);

    // D=-1 ; @0x123 ; D;JGT
    prog[2] = 16'hE301;
    restart;
    step(8);
    chk("jgt_pc", 32'(pc), 32'h3);

    // D=-1 ; @0x20 ; AM=D;JMP -- target and address use the old A
    clear_mem;
    prog[0] = 16'hEE90;
    prog[1] = 16'h0020;
    prog[2] = 16'hE32F;
    restart;
    step(8);
    chk("awj_pc", 32'(pc), 32'h20);
    chk("awj_we_addr", 32'(we_addr), 32'h20);
    chk("awj_we_data", 32'(we_data), 32'hFFFF);
    chk("awj_A", 32'(dut.a_q), 32'hFFFF);

    // @0x7FFF ; 0;JMP ; (0x7FFF) @1 -> pc wraps
    clear_mem;
    prog[0]     = 16'h7FFF;
    prog[1]     = 16'hEA87;
    prog[32767] = 16'h0001;
    restart;
    step(5);
    chk("wrap_pc_top", 32'(pc), 32'h7FFF);
    step(2);
    chk("wrap_pc_zero", 32'(pc), 32'h0);
    chk("wrap_A", 32'(dut.a_q), 32'h1);

    // (0x4) @5 ; (0x5) 0;JMP
    clear_mem;
    prog[4] = 16'h0005;
    prog[5] = 16'hEA87;
    restart;
    step(13);
    chk("self_pc", 32'(pc), 32'h5);
`ifdef HACK_CTRL_HALT_EN
    chk("halt_set", 32'(halted), 32'h1);
    chk("halt_req", 32'(imem_req), 32'h0);
    step(6);
    chk("halt_pc_held", 32'(pc), 32'h5);
    chk("halt_req_held", 32'(imem_req), 32'h0);
    chk("halt_still", 32'(halted), 32'h1);
`else
    chk("nohalt_flag", 32'(halted), 32'h0);
    chk("nohalt_req", 32'(imem_req), 32'h1);
    step(3);
    chk("nohalt_pc_loop", 32'(pc), 32'h5);
    chk("nohalt_flag_loop", 32'(halted), 32'h0);
`endif
    chk("self_no_we", 32'(we_cnt), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
